fifo_flagged: RTL and testbench
===============================

Name: fifo_flagged

Overview:
Parametrised successor to the basic FIFO: single-clock, show-ahead FIFO with guarded read/write, occupancy level output, almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. Used between the CPU bus and serial/terminal peripherals where producers need early back-pressure and firmware needs to detect lost data.

Parameters:
word_bits, 8, data width in bits.
depth_bits, 3, log2 of depth; depth = 1 << depth_bits (min 1).
afull_level, depth - 1, almost_full_out asserts when level >= afull_level (legal range 1..depth).
aempty_level, 1, almost_empty_out asserts when level <= aempty_level (legal range 0..depth-1).

Ports:
clk_in  input  1  clock; all state updates on rising edge.
rst_n_in  input  1  synchronous active-low reset.
data_in  input  word_bits  write data.
write_in  input  1  write request.
read_in  input  1  read request (pops word currently on data_out).
flush_in  input  1  synchronous discard of all contents.
err_clr_in  input  1  clears sticky error flags.
data_out  output  word_bits  word at head of FIFO (show-ahead, combinational from storage).
empty_out  output  1  level == 0.
full_out  output  1  level == depth.
almost_empty_out  output  1  level <= aempty_level.
almost_full_out  output  1  level >= afull_level.
level_out  output  depth_bits+1  current occupancy, 0..depth.
overflow_out  output  1  sticky: write dropped.
underflow_out  output  1  sticky: read on empty.

Behaviour:
- Reset (rst_n_in low at clock edge): read/write pointers 0, level 0, overflow/underflow 0. Outputs after reset: empty 1, full 0, level 0, almost_empty 1, almost_full 0. Storage not cleared; data_out undefined while empty. Reset overrides all other inputs.
- Priority per edge: reset > flush > read/write.
- Flush: pointers and level to 0; read/write ignored that cycle; error flags unchanged.
- Accepted write: write_in & (~full | read_in). Stores data_in at write pointer, pointer +1 mod depth.
- Accepted read: read_in & ~empty. Read pointer +1 mod depth. data_out shows next head in following cycle (zero-latency head; pop takes effect on edge).
- Level: +1 on write-only, -1 on read-only, unchanged on both or neither (accepted events only).
- Full with read and write: both accepted, level stays depth, written word lands in slot freed by read.
- Empty with read and write: read rejected, write accepted, level becomes 1, underflow set.
- Overflow set when write_in & full & ~read_in (word dropped, no state change). Underflow set when read_in & empty. Both sticky until err_clr_in or reset; if set condition and err_clr_in coincide, set wins.
- Pointers are depth_bits wide and wrap naturally; full/empty derived from level only, never from pointer comparison.
- Flags are combinational from registered level; no flag latency beyond the level register.
- Flag outputs with illegal threshold parameters are undefined; bench uses legal values only.

Test Plan:
- Reset then idle (defaults, depth 8): level 0, empty 1, almost_empty 1, full 0, almost_full 0, errors 0.
- Write 0x11..0x18 back-to-back: level climbs 1..8, almost_full at level 7, full at 8; read all 8 -> data_out sequence 0x11..0x18, empty at end, no errors.
- At full, write 0xAA alone -> overflow_out 1, level 8, contents unchanged; then write 0xBB with read same cycle -> level 8, 0xBB appears as 8th word read; err_clr_in pulse -> overflow 0.
- Empty, read_in with write 0x5C same cycle -> underflow 1, level 1, data_out 0x5C next cycle; err_clr_in concurrent with another empty read -> underflow stays 1.
- Wrap: 20 write/read interleaves at level 3 -> data order preserved across pointer wrap; flush_in with write_in high -> level 0, empty 1, write discarded.
- Assert rst_n_in low mid-stream at level 5 with overflow set -> next cycle level 0, empty 1, overflow 0; depth_bits=1, word_bits=16 instance repeats full/empty tests.

Source files
------------

// File: rtl/fifo_flagged_if.sv
// Bus bundle for fifo_flagged: producer/consumer request lines plus the
// FIFO's occupancy and error status, shared by the FIFO and whoever drives it.
interface fifo_flagged_if #(
   parameter int word_bits  = 8,
   parameter int depth_bits = 3
);
   logic [word_bits-1:0]  data_in;
   logic                  write_in;
   logic                  read_in;
   logic                  flush_in;
   logic                  err_clr_in;
   logic [word_bits-1:0]  data_out;
   logic                  empty_out;
   logic                  full_out;
   logic                  almost_empty_out;
   logic                  almost_full_out;
   logic [depth_bits:0]   level_out;
   logic                  overflow_out;
   logic                  underflow_out;

   // Handshake: there is no separate ready line. A write is taken when
   // write_in & (~full_out | read_in); a read is taken when read_in & ~empty_out.
   // Requests outside those windows are dropped and latch overflow/underflow.
   modport master (
      output data_in, write_in, read_in, flush_in, err_clr_in,
      input  data_out, empty_out, full_out, almost_empty_out, almost_full_out,
             level_out, overflow_out, underflow_out
   );

   modport slave (
      input  data_in, write_in, read_in, flush_in, err_clr_in,
      output data_out, empty_out, full_out, almost_empty_out, almost_full_out,
             level_out, overflow_out, underflow_out
   );
endinterface

// File: rtl/fifo_flagged.sv
// Single-clock show-ahead FIFO with occupancy level, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
module fifo_flagged #(
   parameter int word_bits    = 8,
   parameter int depth_bits   = 3,
   parameter int afull_level  = (1 << depth_bits) - 1,
   parameter int aempty_level = 1
) (
   input  logic          clk_in,
   input  logic          rst_n_in,
   fifo_flagged_if.slave bus
);
   localparam int depth = 1 << depth_bits;
   localparam int lvl_w = depth_bits + 1;
   localparam logic [lvl_w-1:0]      depth_lvl  = lvl_w'(depth);
   localparam logic [lvl_w-1:0]      afull_lvl  = lvl_w'(afull_level);
   localparam logic [lvl_w-1:0]      aempty_lvl = lvl_w'(aempty_level);
   localparam logic [lvl_w-1:0]      lvl_one    = lvl_w'(1);
   localparam logic [depth_bits-1:0] ptr_one    = depth_bits'(1);

   logic [word_bits-1:0]  mem_q [depth];
   logic [word_bits-1:0]  mem_d [depth];
   logic [depth_bits-1:0] wr_ptr_q, wr_ptr_d;
   logic [depth_bits-1:0] rd_ptr_q, rd_ptr_d;
   logic [lvl_w-1:0]      level_q, level_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  is_empty, is_full, wr_ok, rd_ok;

   always_comb begin
      is_empty    = (level_q == '0);
      is_full     = (level_q == depth_lvl);
      // A read on a full FIFO frees the slot the concurrent write lands in.
      wr_ok       = bus.write_in & (~is_full | bus.read_in);
      rd_ok       = bus.read_in & ~is_empty;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.flush_in) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (wr_ok) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = wr_ptr_q + ptr_one;
         end
         if (rd_ok) rd_ptr_d = rd_ptr_q + ptr_one;
         if (wr_ok & ~rd_ok)      level_d = level_q + lvl_one;
         else if (rd_ok & ~wr_ok) level_d = level_q - lvl_one;
         // Clear first so a coincident set condition wins.
         if (bus.err_clr_in) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
         end
         if (bus.write_in & is_full & ~bus.read_in) overflow_d  = 1'b1;
         if (bus.read_in & is_empty)                underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left uninitialised by reset.
   always_ff @(posedge clk_in) begin
      if (rst_n_in) mem_q <= mem_d;
   end

   assign bus.data_out         = mem_q[rd_ptr_q];
   assign bus.empty_out        = is_empty;
   assign bus.full_out         = is_full;
   assign bus.almost_empty_out = (level_q <= aempty_lvl);
   assign bus.almost_full_out  = (level_q >= afull_lvl);
   assign bus.level_out        = level_q;
   assign bus.overflow_out     = overflow_q;
   assign bus.underflow_out    = underflow_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a depth-8/8-bit instance and a depth-2/16-bit instance,
// each checked every cycle against a queue model plus directed literal checks.
module tb_fifo_flagged;
   logic clk_in = 1'b0;
   logic rst_n_in = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   model_on = 1'b0;

   always #5 clk_in = ~clk_in;

   fifo_flagged_if #(.word_bits(8), .depth_bits(3))  bus_a ();
   fifo_flagged_if #(.word_bits(16), .depth_bits(1)) bus_b ();

   fifo_flagged #(.word_bits(8), .depth_bits(3)) dut_a (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus_a));
   fifo_flagged #(.word_bits(16), .depth_bits(1)) dut_b (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus_b));

   // Behavioural model: contents as a queue, flags from the request rules.
   logic [7:0]  qa[$];
   logic [15:0] qb[$];
   bit ovf_a = 0, unf_a = 0, ovf_b = 0, unf_b = 0;

   always @(posedge clk_in) begin : model_a
      int n;
      n = qa.size();
      if (!rst_n_in) begin
         qa.delete(); ovf_a = 0; unf_a = 0; model_on = 1'b1;
      end else if (bus_a.flush_in) begin
         qa.delete();
      end else begin
         if (bus_a.err_clr_in) begin ovf_a = 0; unf_a = 0; end
         if (bus_a.write_in && n == 8 && !bus_a.read_in) ovf_a = 1;
         if (bus_a.read_in && n == 0) unf_a = 1;
         if (bus_a.read_in && n > 0) void'(qa.pop_front());
         if (bus_a.write_in && (n < 8 || bus_a.read_in)) qa.push_back(bus_a.data_in);
      end
   end

   always @(posedge clk_in) begin : model_b
      int n;
      n = qb.size();
      if (!rst_n_in) begin
         qb.delete(); ovf_b = 0; unf_b = 0;
      end else if (bus_b.flush_in) begin
         qb.delete();
      end else begin
         if (bus_b.err_clr_in) begin ovf_b = 0; unf_b = 0; end
         if (bus_b.write_in && n == 2 && !bus_b.read_in) ovf_b = 1;
         if (bus_b.read_in && n == 0) unf_b = 1;
         if (bus_b.read_in && n > 0) void'(qb.pop_front());
         if (bus_b.write_in && (n < 2 || bus_b.read_in)) qb.push_back(bus_b.data_in);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: mid-cycle, well away from the active edge.
   always @(negedge clk_in) begin
      if (model_on) begin
         chk("a_level", 32'(bus_a.level_out), 32'(qa.size()));
         chk("a_empty", 32'(bus_a.empty_out), 32'(qa.size() == 0));
         chk("a_full", 32'(bus_a.full_out), 32'(qa.size() == 8));
         chk("a_aempty", 32'(bus_a.almost_empty_out), 32'(qa.size() <= 1));
         chk("a_afull", 32'(bus_a.almost_full_out), 32'(qa.size() >= 7));
         chk("a_ovf", 32'(bus_a.overflow_out), 32'(ovf_a));
         chk("a_unf", 32'(bus_a.underflow_out), 32'(unf_a));
         if (qa.size() > 0) chk("a_data", 32'(bus_a.data_out), 32'(qa[0]));
         chk("b_level", 32'(bus_b.level_out), 32'(qb.size()));
         chk("b_empty", 32'(bus_b.empty_out), 32'(qb.size() == 0));
         chk("b_full", 32'(bus_b.full_out), 32'(qb.size() == 2));
         chk("b_aempty", 32'(bus_b.almost_empty_out), 32'(qb.size() <= 1));
         chk("b_afull", 32'(bus_b.almost_full_out), 32'(qb.size() >= 1));
         chk("b_ovf", 32'(bus_b.overflow_out), 32'(ovf_b));
         chk("b_unf", 32'(bus_b.underflow_out), 32'(unf_b));
         if (qb.size() > 0) chk("b_data", 32'(bus_b.data_out), 32'(qb[0]));
      end
   end

   // Driver tasks: apply inputs just after an edge, hold for one cycle, return idle.
   task automatic cyc_a(input logic w, input logic r, input logic [7:0] d,
                        input logic f, input logic c);
      bus_a.write_in = w; bus_a.read_in = r; bus_a.data_in = d;
      bus_a.flush_in = f; bus_a.err_clr_in = c;
      @(posedge clk_in); #1;
      bus_a.write_in = 0; bus_a.read_in = 0; bus_a.flush_in = 0; bus_a.err_clr_in = 0;
   endtask

   task automatic cyc_b(input logic w, input logic r, input logic [15:0] d,
                        input logic f, input logic c);
      bus_b.write_in = w; bus_b.read_in = r; bus_b.data_in = d;
      bus_b.flush_in = f; bus_b.err_clr_in = c;
      @(posedge clk_in); #1;
      bus_b.write_in = 0; bus_b.read_in = 0; bus_b.flush_in = 0; bus_b.err_clr_in = 0;
   endtask

   initial begin
      bus_a.write_in = 0; bus_a.read_in = 0; bus_a.flush_in = 0; bus_a.err_clr_in = 0;
      bus_a.data_in = '0;
      bus_b.write_in = 0; bus_b.read_in = 0; bus_b.flush_in = 0; bus_b.err_clr_in = 0;
      bus_b.data_in = '0;
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;

      // Reset defaults
      chk("rst_level", 32'(bus_a.level_out), 0);
      chk("rst_empty", 32'(bus_a.empty_out), 1);
      chk("rst_aempty", 32'(bus_a.almost_empty_out), 1);
      chk("rst_full", 32'(bus_a.full_out), 0);
      chk("rst_afull", 32'(bus_a.almost_full_out), 0);
      chk("rst_errs", 32'({bus_a.overflow_out, bus_a.underflow_out}), 0);
      chk("rst_b_empty", 32'(bus_b.empty_out), 1);

      // Fill 0x11..0x18 then drain
      for (int i = 0; i < 8; i++) begin
         cyc_a(1, 0, 8'(8'h11 + i), 0, 0);
         chk("fill_level", 32'(bus_a.level_out), 32'(i + 1));
         chk("fill_afull", 32'(bus_a.almost_full_out), 32'(i + 1 >= 7));
         chk("fill_full", 32'(bus_a.full_out), 32'(i == 7));
      end
      for (int i = 0; i < 8; i++) begin
         chk("drain_data", 32'(bus_a.data_out), 32'(8'h11 + i));
         cyc_a(0, 1, 8'h00, 0, 0);
      end
      chk("drain_empty", 32'(bus_a.empty_out), 1);
      chk("drain_errs", 32'({bus_a.overflow_out, bus_a.underflow_out}), 0);

      // Overflow at full, then write+read at full
      for (int i = 0; i < 8; i++) cyc_a(1, 0, 8'(8'h21 + i), 0, 0);
      cyc_a(1, 0, 8'hAA, 0, 0);
      chk("ovf_set", 32'(bus_a.overflow_out), 1);
      chk("ovf_level", 32'(bus_a.level_out), 8);
      chk("ovf_head", 32'(bus_a.data_out), 32'h21);
      cyc_a(1, 1, 8'hBB, 0, 0);
      chk("wr_rd_full_level", 32'(bus_a.level_out), 8);
      for (int i = 0; i < 8; i++) begin
         chk("wr_rd_full_data", 32'(bus_a.data_out), (i < 7) ? 32'(8'h22 + i) : 32'hBB);
         cyc_a(0, 1, 8'h00, 0, 0);
      end
      cyc_a(0, 0, 8'h00, 0, 1);
      chk("ovf_clr", 32'(bus_a.overflow_out), 0);

      // Underflow with concurrent write on empty
      cyc_a(1, 1, 8'h5C, 0, 0);
      chk("unf_set", 32'(bus_a.underflow_out), 1);
      chk("unf_level", 32'(bus_a.level_out), 1);
      chk("unf_data", 32'(bus_a.data_out), 32'h5C);
      cyc_a(0, 1, 8'h00, 0, 0);
      cyc_a(0, 1, 8'h00, 0, 1);
      chk("unf_set_wins", 32'(bus_a.underflow_out), 1);
      cyc_a(0, 0, 8'h00, 0, 1);
      chk("unf_clr", 32'(bus_a.underflow_out), 0);

      // Pointer wrap at level 3
      for (int i = 0; i < 3; i++) cyc_a(1, 0, 8'(8'h30 + i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         chk("wrap_data", 32'(bus_a.data_out), (i < 3) ? 32'(8'h30 + i) : 32'(8'h40 + i - 3));
         cyc_a(1, 1, 8'(8'h40 + i), 0, 0);
      end
      chk("wrap_level", 32'(bus_a.level_out), 3);
      cyc_a(1, 0, 8'h99, 1, 0);
      chk("flush_level", 32'(bus_a.level_out), 0);
      chk("flush_empty", 32'(bus_a.empty_out), 1);
      cyc_a(0, 0, 8'h00, 0, 0);
      chk("flush_discard", 32'(bus_a.level_out), 0);
      cyc_a(1, 0, 8'h77, 0, 0);
      chk("post_flush_data", 32'(bus_a.data_out), 32'h77);
      cyc_a(0, 1, 8'h00, 0, 0);

      // Reset mid-stream at level 5 with overflow set
      for (int i = 0; i < 8; i++) cyc_a(1, 0, 8'(8'h60 + i), 0, 0);
      cyc_a(1, 0, 8'hAA, 0, 0);
      for (int i = 0; i < 3; i++) cyc_a(0, 1, 8'h00, 0, 0);
      chk("pre_rst_level", 32'(bus_a.level_out), 5);
      chk("pre_rst_ovf", 32'(bus_a.overflow_out), 1);
      rst_n_in = 1'b0;
      cyc_a(1, 1, 8'h12, 0, 0);
      rst_n_in = 1'b1;
      chk("mid_rst_level", 32'(bus_a.level_out), 0);
      chk("mid_rst_empty", 32'(bus_a.empty_out), 1);
      chk("mid_rst_ovf", 32'(bus_a.overflow_out), 0);

      // Depth-2, 16-bit instance: full/empty corners
      cyc_b(1, 0, 16'h1234, 0, 0);
      chk("b_l1", 32'(bus_b.level_out), 1);
      chk("b_l1_flags", 32'({bus_b.almost_full_out, bus_b.almost_empty_out, bus_b.full_out}), 32'b110);
      cyc_b(1, 0, 16'hBEEF, 0, 0);
      chk("b_full_set", 32'(bus_b.full_out), 1);
      chk("b_l2_aempty", 32'(bus_b.almost_empty_out), 0);
      cyc_b(1, 0, 16'hCAFE, 0, 0);
      chk("b_ovf_set", 32'(bus_b.overflow_out), 1);
      chk("b_ovf_head", 32'(bus_b.data_out), 32'h1234);
      cyc_b(1, 1, 16'hD00D, 0, 0);
      chk("b_wr_rd_level", 32'(bus_b.level_out), 2);
      chk("b_wr_rd_head", 32'(bus_b.data_out), 32'hBEEF);
      cyc_b(0, 1, 16'h0000, 0, 0);
      chk("b_next_head", 32'(bus_b.data_out), 32'hD00D);
      cyc_b(0, 1, 16'h0000, 0, 0);
      chk("b_empty_set", 32'(bus_b.empty_out), 1);
      cyc_b(1, 1, 16'h5A5A, 0, 0);
      chk("b_unf_set", 32'(bus_b.underflow_out), 1);
      chk("b_unf_data", 32'(bus_b.data_out), 32'h5A5A);
      cyc_b(0, 0, 16'h0000, 0, 1);
      chk("b_errs_clr", 32'({bus_b.overflow_out, bus_b.underflow_out}), 0);

      repeat (2) @(posedge clk_in);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
